// File: rtl/link_test_sequencer.sv
// Run-control FSM for the PRBS7 receive extractor: reset, lock wait,
// windowed error accumulation with retry, and pass/fail reporting.
module link_test_sequencer #(
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int WINDOW       = 1048576,
    parameter int MAX_RETRY    = 3,
    parameter int ERR_W        = 7,
    parameter int ACC_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             bypass_cfg,
    input  logic             aligned_in,
    input  logic [ERR_W-1:0] err_in,
    output logic             ext_reset,
    output logic             bypass,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [3:0]       attempts,
    output logic [ACC_W-1:0] err_total
);

    localparam int CNT_MAX0 =
        (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX =
        (CNT_MAX0 > WINDOW) ? CNT_MAX0 : WINDOW;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [4:0]       ATT_LIMIT = 5'(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        LOCK,
        MEAS,
        DONE
    } stateT;

    stateT            state, stateNext;
    logic [CNT_W-1:0] count, countNext;
    logic             extResetNext, bypassNext, busyNext;
    logic             doneNext, passNext, timeoutNext;
    logic [3:0]       attemptsNext;
    logic [ACC_W-1:0] errNext;
    logic             failNow;

    // Saturating accumulate of this cycle's error count.
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sumSat;

    assign sum = {1'b0, err_total}
               + {{(ACC_W + 1 - ERR_W){1'b0}}, err_in};
    assign sumSat = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

    always_comb begin
        stateNext    = state;
        countNext    = count;
        extResetNext = ext_reset;
        bypassNext   = bypass;
        busyNext     = busy;
        doneNext     = 1'b0;
        passNext     = pass;
        timeoutNext  = timeout;
        attemptsNext = attempts;
        errNext      = err_total;
        failNow      = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext    = RST;
                    countNext    = '0;
                    extResetNext = 1'b1;
                    bypassNext   = bypass_cfg;
                    busyNext     = 1'b1;
                    passNext     = 1'b0;
                    timeoutNext  = 1'b0;
                    attemptsNext = 4'd1;
                    errNext      = '0;
                end
            end
            RST: begin
                if (count == RST_LAST) begin
                    stateNext    = LOCK;
                    countNext    = '0;
                    extResetNext = 1'b0;
                end else begin
                    countNext = count + 1'b1;
                end
            end
            LOCK: begin
                if (aligned_in) begin
                    stateNext = MEAS;
                    countNext = '0;
                    errNext   = '0;
                end else if (count == LOCK_LAST) begin
                    failNow = 1'b1;
                end else begin
                    countNext = count + 1'b1;
                end
            end
            MEAS: begin
                if (!aligned_in) begin
                    failNow = 1'b1;
                end else begin
                    errNext = sumSat;
                    if (count == WIN_LAST) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                        busyNext  = 1'b0;
                        passNext  = (sumSat == '0);
                    end else begin
                        countNext = count + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (failNow) begin
            if ({1'b0, attempts} < ATT_LIMIT) begin
                stateNext    = RST;
                countNext    = '0;
                extResetNext = 1'b1;
                attemptsNext = attempts + 4'd1;
            end else begin
                stateNext   = DONE;
                doneNext    = 1'b1;
                busyNext    = 1'b0;
                passNext    = 1'b0;
                timeoutNext = 1'b1;
            end
        end

        // Abort beats everything, including a same-cycle start.
        if (abort) begin
            stateNext    = IDLE;
            countNext    = count;
            extResetNext = 1'b1;
            bypassNext   = bypass;
            busyNext     = 1'b0;
            doneNext     = 1'b0;
            passNext     = pass;
            timeoutNext  = timeout;
            attemptsNext = attempts;
            errNext      = err_total;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            ext_reset <= 1'b1;
            bypass    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            attempts  <= '0;
            err_total <= '0;
        end else begin
            state     <= stateNext;
            count     <= countNext;
            ext_reset <= extResetNext;
            bypass    <= bypassNext;
            busy      <= busyNext;
            done      <= doneNext;
            pass      <= passNext;
            timeout   <= timeoutNext;
            attempts  <= attemptsNext;
            err_total <= errNext;
        end
    end

endmodule

// File: tb/tb_link_test_sequencer.sv
// Bench for link_test_sequencer: two parameterisations driven in
// parallel, checked each cycle against a phase/elapsed-time model.
module tb_link_test_sequencer;

    localparam int RSTC  = 4;
    localparam int LOCKT = 100;
    localparam int WIN   = 1000;

    localparam int P_IDLE = 0;
    localparam int P_RST  = 1;
    localparam int P_LOCK = 2;
    localparam int P_MEAS = 3;
    localparam int P_DONE = 4;

    typedef struct {
        int     phase;
        int     el;
        bit     extReset;
        bit     bypass;
        bit     busy;
        bit     done;
        bit     pass;
        bit     timeout;
        int     attempts;
        longint errTotal;
    } mdlT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bypassCfg = 1'b0;
    logic       alignedIn = 1'b0;
    logic [6:0] errIn = '0;

    logic        extResetA, bypassA, busyA, doneA, passA, timeoutA;
    logic [3:0]  attemptsA;
    logic [31:0] errTotalA;
    logic        extResetB, bypassB, busyB, doneB, passB, timeoutB;
    logic [3:0]  attemptsB;
    logic [7:0]  errTotalB;

    int  nCmp = 0;
    int  nBad = 0;
    bit  armed = 1'b0;
    int  rstHighA = 0;
    mdlT mA, mB;

    always #5 clk = ~clk;

    link_test_sequencer #(
        .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LOCKT), .WINDOW(WIN),
        .MAX_RETRY(2), .ERR_W(7), .ACC_W(32)
    ) dutA (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .bypass_cfg(bypassCfg), .aligned_in(alignedIn),
        .err_in(errIn), .ext_reset(extResetA), .bypass(bypassA),
        .busy(busyA), .done(doneA), .pass(passA),
        .timeout(timeoutA), .attempts(attemptsA),
        .err_total(errTotalA)
    );

    link_test_sequencer #(
        .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LOCKT), .WINDOW(WIN),
        .MAX_RETRY(0), .ERR_W(7), .ACC_W(8)
    ) dutB (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .bypass_cfg(bypassCfg), .aligned_in(alignedIn),
        .err_in(errIn), .ext_reset(extResetB), .bypass(bypassB),
        .busy(busyB), .done(doneB), .pass(passB),
        .timeout(timeoutB), .attempts(attemptsB),
        .err_total(errTotalB)
    );

    task automatic failAttempt(inout mdlT m, input int maxR);
        if (m.attempts <= maxR) begin
            m.attempts = m.attempts + 1;
            m.phase    = P_RST;
            m.el       = 0;
            m.extReset = 1'b1;
        end else begin
            m.phase   = P_DONE;
            m.done    = 1'b1;
            m.busy    = 1'b0;
            m.pass    = 1'b0;
            m.timeout = 1'b1;
        end
    endtask

    task automatic mstep(inout mdlT m, input int maxR,
                         input longint accMax);
        longint s;
        m.done = 1'b0;
        if (reset) begin
            m.phase = P_IDLE; m.el = 0; m.extReset = 1'b1;
            m.bypass = 1'b0; m.busy = 1'b0; m.pass = 1'b0;
            m.timeout = 1'b0; m.attempts = 0; m.errTotal = 0;
        end else if (abort) begin
            m.phase    = P_IDLE;
            m.extReset = 1'b1;
            m.busy     = 1'b0;
        end else begin
            case (m.phase)
                P_IDLE, P_DONE: if (start) begin
                    m.phase = P_RST; m.el = 0; m.extReset = 1'b1;
                    m.bypass = bypassCfg; m.busy = 1'b1;
                    m.pass = 1'b0; m.timeout = 1'b0;
                    m.attempts = 1; m.errTotal = 0;
                end
                P_RST: begin
                    m.el = m.el + 1;
                    if (m.el == RSTC) begin
                        m.phase = P_LOCK; m.el = 0; m.extReset = 1'b0;
                    end
                end
                P_LOCK: begin
                    if (alignedIn) begin
                        m.phase = P_MEAS; m.el = 0; m.errTotal = 0;
                    end else begin
                        m.el = m.el + 1;
                        if (m.el == LOCKT) failAttempt(m, maxR);
                    end
                end
                P_MEAS: begin
                    if (!alignedIn) begin
                        failAttempt(m, maxR);
                    end else begin
                        s = m.errTotal + longint'(errIn);
                        m.errTotal = (s > accMax) ? accMax : s;
                        m.el = m.el + 1;
                        if (m.el == WIN) begin
                            m.phase = P_DONE; m.done = 1'b1;
                            m.busy = 1'b0;
                            m.pass = (m.errTotal == 0);
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk) begin
        mdlT ta, tb;
        ta = mA;
        tb = mB;
        mstep(ta, 2, 64'hFFFF_FFFF);
        mstep(tb, 0, 255);
        mA <= ta;
        mB <= tb;
    end

    task automatic cmpDut(input string nm, input logic [5:0] f,
                          input logic [3:0] att,
                          input logic [63:0] et, input mdlT m);
        logic [5:0] ef;
        ef = {m.extReset, m.bypass, m.busy, m.done, m.pass, m.timeout};
        nCmp++;
        if (f !== ef || att !== 4'(m.attempts) ||
            et !== 64'(m.errTotal)) begin
            nBad++;
            $display("FAIL model_%s t=%0t flags=%b/%b att=%0d/%0d err=%0d/%0d",
                     nm, $time, f, ef, att, m.attempts, et, m.errTotal);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmpDut("A", {extResetA, bypassA, busyA, doneA, passA,
                   timeoutA}, attemptsA, {32'b0, errTotalA}, mA);
            cmpDut("B", {extResetB, bypassB, busyB, doneB, passB,
                   timeoutB}, attemptsB, {56'b0, errTotalB}, mB);
            if (busyA && extResetA) rstHighA++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseStart(input bit cfg);
        start     = 1'b1;
        bypassCfg = cfg;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDoneA(input int limit, output int n);
        n = 0;
        while (!doneA && n < limit) begin
            tick();
            n++;
        end
        if (!doneA) chk("done_wait_expired", 0, 1);
    endtask

    initial begin
        int n, r0;
        // 1: reset release, idle
        tick(2);
        armed = 1'b1;
        reset = 1'b0;
        tick(100);
        chk("idle_ext_reset", extResetA, 1);
        chk("idle_busy", busyA, 0);
        chk("idle_status", {doneA, passA, timeoutA, attemptsA}, 0);
        chk("idle_err_total", errTotalA, 0);

        // 2: clean run
        r0 = rstHighA;
        pulseStart(1'b1);
        tick(53);
        alignedIn = 1'b1;
        waitDoneA(2000, n);
        chk("t2_done_latency", n, 1001);
        chk("t2_pass", passA, 1);
        chk("t2_attempts", attemptsA, 1);
        chk("t2_bypass", bypassA, 1);
        chk("t2_rst_cycles", rstHighA - r0, 4);

        // 3: five cycles of 3 errors, start while busy ignored
        alignedIn = 1'b0;
        tick();
        pulseStart(1'b0);
        tick(9);
        alignedIn = 1'b1;
        tick(20);
        errIn = 7'd3;
        tick(5);
        errIn = 7'd0;
        tick(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDoneA(2000, n);
        chk("t3_done_latency", n, 970);
        chk("t3_err_total", errTotalA, 15);
        chk("t3_pass_timeout", {passA, timeoutA}, 0);

        // 4: never aligns
        alignedIn = 1'b0;
        r0 = rstHighA;
        pulseStart(1'b0);
        tick(103);
        chk("t4_b_no_done_yet", doneB, 0);
        tick();
        chk("t4_b_done", {doneB, timeoutB, attemptsB}, 6'b11_0001);
        waitDoneA(2000, n);
        chk("t4_done_latency", n, 208);
        chk("t4_attempts", attemptsA, 3);
        chk("t4_timeout_pass", {timeoutA, passA}, 2'b10);
        chk("t4_rst_cycles", rstHighA - r0, 12);

        // 5: lock loss on attempt 1, clean attempt 2
        pulseStart(1'b0);
        tick(9);
        alignedIn = 1'b1;
        tick(10);
        errIn = 7'd5;
        tick(4);
        errIn = 7'd0;
        tick(276);
        alignedIn = 1'b0;
        tick();
        chk("t5_b_err_total", errTotalB, 20);
        chk("t5_b_timeout", {doneB, timeoutB}, 2'b11);
        tick(19);
        alignedIn = 1'b1;
        waitDoneA(2000, n);
        chk("t5_done_latency", n, 1001);
        chk("t5_attempts", attemptsA, 2);
        chk("t5_pass", passA, 1);
        chk("t5_err_total", errTotalA, 0);

        // 6: saturation, abort, start+abort
        alignedIn = 1'b0;
        errIn = 7'd127;
        pulseStart(1'b1);
        tick(9);
        alignedIn = 1'b1;
        tick(10);
        chk("t6_b_saturated", errTotalB, 255);
        chk("t6_a_sum", errTotalA, 1143);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_state", {busyA, extResetA, doneA}, 3'b010);
        chk("t6_abort_hold", errTotalB, 255);
        tick(3);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_start_abort", {busyA, busyB}, 0);
        tick(3);

        // reset mid-run
        errIn = 7'd0;
        alignedIn = 1'b0;
        pulseStart(1'b0);
        tick(20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_run", {busyA, extResetA, attemptsA}, 6'b01_0000);
        chk("rst_mid_err", errTotalA, 0);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
